// File: rtl/cache_pkg.sv
// Shared parameters, field positions, FSM encodings and entry helpers for the
// 4-way cache write-side controller.
package cache_pkg;
    localparam int WAYS            = 4;
    localparam int LINE_SIZE_BYTES = 4;
    localparam int OFF_BITS        = $clog2(LINE_SIZE_BYTES);
    localparam int TAG_BITS        = 18;
    localparam int INDEX_BITS      = 12;
    localparam int DATA_W          = LINE_SIZE_BYTES * 8;
    localparam int ADDR_BITS       = TAG_BITS + INDEX_BITS + OFF_BITS;
    localparam int ENTRY_W         = 3 + TAG_BITS + DATA_W;

    localparam int DATA_LSB  = 0;
    localparam int TAG_LSB   = DATA_W;
    localparam int DIRTY_BIT = TAG_LSB + TAG_BITS;
    localparam int LRU_BIT   = DIRTY_BIT + 1;
    localparam int VALID_BIT = LRU_BIT + 1;

    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_READ      = 3'd1;
    localparam state_t ST_WB_REQ    = 3'd2;
    localparam state_t ST_FILL_REQ  = 3'd3;
    localparam state_t ST_FILL_WAIT = 3'd4;
    localparam state_t ST_WRITE     = 3'd5;

    typedef struct packed {
        logic                valid;
        logic                lru;
        logic                dirty;
        logic [TAG_BITS-1:0] tag;
        logic [DATA_W-1:0]   data;
    } entry_t;

    function automatic entry_t unpack_entry(input logic [ENTRY_W-1:0] raw);
        entry_t e;
        e.valid = raw[VALID_BIT];
        e.lru   = raw[LRU_BIT];
        e.dirty = raw[DIRTY_BIT];
        e.tag   = raw[TAG_LSB +: TAG_BITS];
        e.data  = raw[DATA_LSB +: DATA_W];
        return e;
    endfunction

    function automatic logic [ENTRY_W-1:0] pack_entry(input entry_t e);
        logic [ENTRY_W-1:0] raw;
        raw                        = '0;
        raw[VALID_BIT]             = e.valid;
        raw[LRU_BIT]               = e.lru;
        raw[DIRTY_BIT]             = e.dirty;
        raw[TAG_LSB +: TAG_BITS]   = e.tag;
        raw[DATA_LSB +: DATA_W]    = e.data;
        return raw;
    endfunction

    // Lowest set bit wins; an all-zero vector yields zero.
    function automatic logic [WAYS-1:0] lowest_one(input logic [WAYS-1:0] v);
        logic [WAYS-1:0] r;
        r = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (v[i]) begin
                r    = '0;
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction
endpackage

// File: rtl/way_victim_sel.sv
// Tag compare and victim choice across the four ways of one set; purely
// combinational, evaluated on the entries as they come back from the array.
module way_victim_sel
    import cache_pkg::*;
(
    input  logic [WAYS-1:0]                valid_vec,
    input  logic [WAYS-1:0]                lru_vec,
    input  logic [WAYS-1:0]                dirty_vec,
    input  logic [WAYS-1:0][TAG_BITS-1:0]  tags,
    input  logic [TAG_BITS-1:0]            req_tag,
    output logic [WAYS-1:0]                hit_oh,
    output logic                           hit,
    output logic [WAYS-1:0]                victim_oh,
    output logic                           victim_dirty,
    output logic                           others_lru_set
);
    logic [WAYS-1:0] hit_vec;
    logic [WAYS-1:0] target_oh;

    always_comb begin
        hit_vec = '0;
        for (int w = 0; w < WAYS; w++) begin
            hit_vec[w] = valid_vec[w] && (tags[w] == req_tag);
        end
    end

    assign hit    = |hit_vec;
    assign hit_oh = lowest_one(hit_vec);

    always_comb begin
        victim_oh = '0;
        if (!(&valid_vec)) begin
            victim_oh = lowest_one(~valid_vec);
        end else if (!(&lru_vec)) begin
            victim_oh = lowest_one(~lru_vec);
        end else begin
            victim_oh[0] = 1'b1;
        end
    end

    // An invalid victim carries nothing worth writing back.
    assign victim_dirty   = |(victim_oh & valid_vec & dirty_vec);
    assign target_oh      = hit ? hit_oh : victim_oh;
    assign others_lru_set = &(target_oh | ~valid_vec | lru_vec);
endmodule

// File: rtl/cache_way_writer.sv
// Write-side controller: one load/store per pass, tag compare, optional dirty
// write-back and line fill, then a single packed entry write into the chosen way.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | ready for a request; accept pulses the array read
// READ      | entries arrive; latch target way, hit and victim info
// WB_REQ    | write dirty victim line to memory, hold until ready
// FILL_REQ  | request the missing line from memory, hold until ready
// FILL_WAIT | wait for fill data
// WRITE     | one-hot way write, o_done pulse, LRU clear of the other ways
module cache_way_writer
    import cache_pkg::*;
(
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_req_valid,
    output logic                       o_req_ready,
    input  logic                       i_req_write,
    input  logic [TAG_BITS-1:0]        i_req_tag,
    input  logic [INDEX_BITS-1:0]      i_req_index,
    input  logic [DATA_W-1:0]          i_req_wdata,
    input  logic [LINE_SIZE_BYTES-1:0] i_req_be,
    output logic                       o_rd_en,
    output logic [INDEX_BITS-1:0]      o_rd_index,
    input  logic [ENTRY_W-1:0]         i_way_0,
    input  logic [ENTRY_W-1:0]         i_way_1,
    input  logic [ENTRY_W-1:0]         i_way_2,
    input  logic [ENTRY_W-1:0]         i_way_3,
    output logic [WAYS-1:0]            o_way_we,
    output logic [INDEX_BITS-1:0]      o_way_index,
    output logic [ENTRY_W-1:0]         o_way_entry,
    output logic [WAYS-1:0]            o_lru_clr,
    output logic                       o_mem_req_valid,
    input  logic                       i_mem_req_ready,
    output logic                       o_mem_req_write,
    output logic [ADDR_BITS-1:0]       o_mem_addr,
    output logic [DATA_W-1:0]          o_mem_wdata,
    input  logic                       i_mem_rdata_valid,
    input  logic [DATA_W-1:0]          i_mem_rdata,
    output logic                       o_done,
    output logic [DATA_W-1:0]          o_rdata
);
    state_t state, state_nx;

    logic                       req_write_q;
    logic [TAG_BITS-1:0]        tag_q;
    logic [INDEX_BITS-1:0]      idx_q;
    logic [DATA_W-1:0]          wdata_q;
    logic [LINE_SIZE_BYTES-1:0] be_q;
    logic [WAYS-1:0]            tgt_oh_q;
    logic                       hit_q;
    logic                       lru_ok_q;
    logic [TAG_BITS-1:0]        old_tag_q;
    logic [DATA_W-1:0]          old_data_q;
    logic                       old_dirty_q;
    logic [DATA_W-1:0]          fill_q;

    entry_t [WAYS-1:0]               live_e;
    logic [WAYS-1:0]                 live_valid, live_lru, live_dirty;
    logic [WAYS-1:0][TAG_BITS-1:0]   live_tag;
    logic [WAYS-1:0]                 sel_hit_oh, sel_victim_oh, tgt_nx;
    logic                            sel_hit, sel_victim_dirty, sel_lru_ok;
    logic [TAG_BITS-1:0]             tgt_tag;
    logic [DATA_W-1:0]               tgt_data;
    logic                            tgt_dirty;
    logic                            accept;
    logic [DATA_W-1:0]               base, merged;
    entry_t                          new_e;

    always_comb begin
        live_e[0] = unpack_entry(i_way_0);
        live_e[1] = unpack_entry(i_way_1);
        live_e[2] = unpack_entry(i_way_2);
        live_e[3] = unpack_entry(i_way_3);
        for (int w = 0; w < WAYS; w++) begin
            live_valid[w] = live_e[w].valid;
            live_lru[w]   = live_e[w].lru;
            live_dirty[w] = live_e[w].dirty;
            live_tag[w]   = live_e[w].tag;
        end
    end

    way_victim_sel u_sel (
        .valid_vec      (live_valid),
        .lru_vec        (live_lru),
        .dirty_vec      (live_dirty),
        .tags           (live_tag),
        .req_tag        (tag_q),
        .hit_oh         (sel_hit_oh),
        .hit            (sel_hit),
        .victim_oh      (sel_victim_oh),
        .victim_dirty   (sel_victim_dirty),
        .others_lru_set (sel_lru_ok)
    );

    assign tgt_nx = sel_hit ? sel_hit_oh : sel_victim_oh;

    always_comb begin
        tgt_tag   = '0;
        tgt_data  = '0;
        tgt_dirty = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (tgt_nx[w]) begin
                tgt_tag   = live_e[w].tag;
                tgt_data  = live_e[w].data;
                tgt_dirty = live_e[w].dirty;
            end
        end
    end

    assign accept = (state == ST_IDLE) && i_req_valid;

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:      if (i_req_valid) state_nx = ST_READ;
            ST_READ: begin
                if (sel_hit)               state_nx = ST_WRITE;
                else if (sel_victim_dirty) state_nx = ST_WB_REQ;
                else                       state_nx = ST_FILL_REQ;
            end
            ST_WB_REQ:    if (i_mem_req_ready)   state_nx = ST_FILL_REQ;
            ST_FILL_REQ:  if (i_mem_req_ready)   state_nx = ST_FILL_WAIT;
            ST_FILL_WAIT: if (i_mem_rdata_valid) state_nx = ST_WRITE;
            ST_WRITE:     state_nx = ST_IDLE;
            default:      state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= ST_IDLE;
            req_write_q <= 1'b0;
            tag_q       <= '0;
            idx_q       <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            tgt_oh_q    <= '0;
            hit_q       <= 1'b0;
            lru_ok_q    <= 1'b0;
            old_tag_q   <= '0;
            old_data_q  <= '0;
            old_dirty_q <= 1'b0;
            fill_q      <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                req_write_q <= i_req_write;
                tag_q       <= i_req_tag;
                idx_q       <= i_req_index;
                wdata_q     <= i_req_wdata;
                be_q        <= i_req_be;
            end
            if (state == ST_READ) begin
                tgt_oh_q    <= tgt_nx;
                hit_q       <= sel_hit;
                lru_ok_q    <= sel_lru_ok;
                old_tag_q   <= tgt_tag;
                old_data_q  <= tgt_data;
                old_dirty_q <= tgt_dirty;
            end
            if ((state == ST_FILL_WAIT) && i_mem_rdata_valid) begin
                fill_q <= i_mem_rdata;
            end
        end
    end

    always_comb begin
        base   = hit_q ? old_data_q : fill_q;
        merged = base;
        for (int b = 0; b < LINE_SIZE_BYTES; b++) begin
            if (req_write_q && be_q[b]) merged[b*8 +: 8] = wdata_q[b*8 +: 8];
        end
        new_e.valid = 1'b1;
        new_e.lru   = 1'b1;
        new_e.dirty = req_write_q | (hit_q & old_dirty_q);
        new_e.tag   = tag_q;
        new_e.data  = merged;
    end

    // Outputs are zeroed outside their owning state so reset leaves them all quiet.
    assign o_req_ready     = (state == ST_IDLE);
    assign o_rd_en         = accept;
    assign o_rd_index      = accept ? i_req_index : '0;
    assign o_done          = (state == ST_WRITE);
    assign o_way_we        = o_done ? tgt_oh_q : '0;
    assign o_way_index     = o_done ? idx_q : '0;
    assign o_way_entry     = o_done ? pack_entry(new_e) : '0;
    assign o_rdata         = o_done ? merged : '0;
    assign o_lru_clr       = (o_done && lru_ok_q) ? ~tgt_oh_q : '0;
    assign o_mem_req_valid = (state == ST_WB_REQ) || (state == ST_FILL_REQ);
    assign o_mem_req_write = (state == ST_WB_REQ);
    assign o_mem_wdata     = (state == ST_WB_REQ) ? old_data_q : '0;

    always_comb begin
        o_mem_addr = '0;
        if (state == ST_WB_REQ)   o_mem_addr = {old_tag_q, idx_q, {OFF_BITS{1'b0}}};
        if (state == ST_FILL_REQ) o_mem_addr = {tag_q, idx_q, {OFF_BITS{1'b0}}};
    end
endmodule

// File: doc/cache_way_writer.md
# cache_way_writer

Write-side controller for the 4-way set-associative cache: accepts one CPU load/store request, compares tags across the four way entries, and picks a target way (hit way, or a victim on a miss). It sequences dirty write-back and line fill over the memory port, then writes a fully packed entry back into the selected way with a one-hot write enable. It is the counterpart of the per-way read mux and uses the same entry packing, MSB to LSB: {valid, lru, dirty, tag, data}. Data occupies bits [LINE_SIZE_BYTES*8-1:0].

## Interface
- WAYS, 4, number of ways; the design is fixed at 4.
- LINE_SIZE_BYTES, 4, bytes per line; OFF_BITS = log2(LINE_SIZE_BYTES).
- LRU_BITS / VALID_BITS / DIRTY_BITS, 1 / 1 / 1, per-entry status field widths.
- TAG_BITS, 18, tag width.
- INDEX_BITS, 12, set index width. ADDR_BITS = TAG_BITS + INDEX_BITS + OFF_BITS (32). ENTRY_W = 3 + TAG_BITS + LINE_SIZE_BYTES*8.
- Clocking and reset (already decided): one clock; reset is asynchronous and active-low.
- i_clk  in  1  clock; all state changes on the rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_req_valid / o_req_ready  in / out  1  request handshake.
- i_req_write  in  1  1 = store, 0 = load.
- i_req_tag / i_req_index  in  TAG_BITS / INDEX_BITS  request address fields.
- i_req_wdata / i_req_be  in  LINE_SIZE_BYTES*8 / LINE_SIZE_BYTES  store data and byte enables.
- o_rd_en / o_rd_index  out  1 / INDEX_BITS  array read; entries return on the next cycle.
- i_way_0..i_way_3  in  ENTRY_W  way entries at o_rd_index.
- o_way_we  out  WAYS  one-hot write enable; o_way_index  out  INDEX_BITS; o_way_entry  out  ENTRY_W.
- o_lru_clr  out  WAYS  clears the LRU bit of the flagged ways in the same cycle as the write.
- o_mem_req_valid / i_mem_req_ready  out / in  1  memory request handshake; o_mem_req_write  out  1; o_mem_addr  out  ADDR_BITS; o_mem_wdata  out  LINE_SIZE_BYTES*8.
- i_mem_rdata_valid / i_mem_rdata  in  1 / LINE_SIZE_BYTES*8  fill return.
- o_done  out  1  one-cycle pulse when the request completes; o_rdata  out  LINE_SIZE_BYTES*8  final line, valid with o_done.

## Operation
- States: IDLE, READ, WB_REQ, FILL_REQ, FILL_WAIT, WRITE.
- IDLE:
  - o_req_ready = 1.
  - On valid & ready: latch the request, pulse o_rd_en with o_rd_index = i_req_index, go to READ.
- READ: latch the four entries and compute:
  - hit[w] = valid & (tag == req tag). If more than one way hits, the lowest index wins.
  - Victim: lowest-index invalid way; otherwise lowest-index way with lru = 0; otherwise way 0.
  - Transitions: hit → WRITE; miss with dirty victim → WB_REQ; miss with clean victim → FILL_REQ.
- WB_REQ: o_mem_req_write = 1, o_mem_addr = {victim tag, index, 0}, o_mem_wdata = victim data. Held stable until i_mem_req_ready, then go to FILL_REQ.
- FILL_REQ: o_mem_req_write = 0, o_mem_addr = {req tag, index, 0}. Held stable until ready, then go to FILL_WAIT.
- FILL_WAIT: on i_mem_rdata_valid, latch i_mem_rdata and go to WRITE.
- WRITE: o_way_we = onehot(target), o_done = 1, then return to IDLE. The written entry is:
  - valid = 1, lru = 1, tag = req tag.
  - dirty = 1 on a store; on a load, the old dirty bit if hit, else 0.
  - data = base merged with i_req_wdata per byte enable on a store, base unchanged on a load. Base = old data (hit) or fill data (miss).
- o_rdata = the written data.
- o_lru_clr = every way except the target, asserted only when all other valid ways have lru = 1; else 0.
- i_mem_rdata_valid is ignored outside FILL_WAIT.

## Timing
- Reset: state IDLE; every output 0 except o_req_ready = 1; all latched request and entry registers cleared.
- Hit latency: accept at cycle 0, entries at cycle 1, write and o_done at cycle 2.
- Miss latency: 2 cycles plus memory handshake waits plus fill latency. No request is accepted again until the cycle after o_done.
- Memory request outputs hold stable while valid and not ready. o_way_we is never asserted outside WRITE.
- A store with be = 0 still sets dirty and LRU, and leaves data unchanged.
- Reset asserted mid-operation: return to IDLE immediately; no way write is issued; the outstanding memory transaction is abandoned.

## Structure
- Package cache_pkg: ENTRY_W and field bit positions (DATA_LSB, TAG_LSB, DIRTY_BIT, LRU_BIT, VALID_BIT), the state enum, and an entry pack/unpack function.
- Sub-module way_victim_sel (combinational): takes the four entries and the request tag; outputs hit one-hot, hit flag, victim one-hot, victim dirty, and the all-other-LRU-set flag.

## Test plan
- Store hit: way 2 valid, tag 0x1234, data 0xAABBCCDD; store be = 0b0011, wdata 0x11223344 → cycle 2: o_way_we = 0b0100, data 0xAABB3344, dirty = 1, o_done = 1.
- Load miss, way 1 invalid → FILL_REQ addr {tag, index, 00}; fill returns 0xDEADBEEF → o_way_we = 0b0010, dirty = 0, o_rdata = 0xDEADBEEF.
- Load miss, all valid, way 0 lru = 0 and dirty → WB_REQ with victim tag and data first, then fill; i_mem_req_ready held low 3 cycles → outputs stable throughout.
- Hit on way 3 with ways 0-2 lru = 1 → o_lru_clr = 0b0111 together with o_way_we = 0b1000.
- Reset pulsed during FILL_WAIT → outputs return to reset values; a later fill return produces no way write.
- Tag matches in ways 1 and 2 → way 1 is written.
